// File: rtl/ldw_ctrl.sv
// Multi-cycle load/store/branch controller: sequences FETCH, DECODE, EXEC,
// MEM, WB, BRANCH and JUMP for a MIPS-like datapath. A memory wait watchdog
// traps into a sticky TRAP state, which only reset can leave.
module ldw_ctrl #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ack,
  input  logic        alu_z,
  output logic        ir_we,
  output logic        pc_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [1:0]  alu_src_a,
  output logic [2:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic [2:0]  state,
  output logic        trap
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0100,
    OP_AND = 4'b0001,
    OP_OR  = 4'b0101,
    OP_XOR = 4'b0010,
    OP_LUI = 4'b0110,
    OP_SLL = 4'b0011,
    OP_SRL = 4'b0111,
    OP_SRA = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    C_EXEC,
    C_BRANCH,
    C_JUMP,
    C_ILLEGAL
  } iclass_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  // Last wait count that may still be followed by an ack without trapping.
  localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [5:0] opcode_q, funct_q;

  // Raw strobes before the reset gate.
  logic ir_we_c, pc_we_c, mem_req_c, mem_we_c, reg_we_c;

  // Decoded view of the latched instruction.
  iclass_e  cls;
  alu_op_e  ex_op;
  logic [1:0] ex_src_a;
  logic [2:0] ex_src_b;
  logic is_r, is_lw, is_sw, is_bne;

  // Only opcode and funct steer the controller; the register and immediate
  // fields belong to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:6];

  // Classify the latched instruction and pick its EXEC operands and ALU op.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    cls      = C_ILLEGAL;
    ex_op    = OP_ADD;
    ex_src_a = 2'b01;
    ex_src_b = 3'b000;
    is_r     = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_bne   = 1'b0;
    case (opcode_q)
      OPC_RTYPE: begin
        is_r = 1'b1;
        cls  = C_EXEC;
        case (funct_q)
          FN_ADD: ex_op = OP_ADD;
          FN_SUB: ex_op = OP_SUB;
          FN_AND: ex_op = OP_AND;
          FN_OR:  ex_op = OP_OR;
          FN_XOR: ex_op = OP_XOR;
          FN_SLL: begin ex_op = OP_SLL; ex_src_a = 2'b10; end
          FN_SRL: begin ex_op = OP_SRL; ex_src_a = 2'b10; end
          FN_SRA: begin ex_op = OP_SRA; ex_src_a = 2'b10; end
          default: cls = C_ILLEGAL;
        endcase
      end
      OPC_ADDI: begin cls = C_EXEC; ex_src_b = 3'b010; end
      OPC_ANDI: begin cls = C_EXEC; ex_src_b = 3'b011; ex_op = OP_AND; end
      OPC_ORI:  begin cls = C_EXEC; ex_src_b = 3'b011; ex_op = OP_OR;  end
      OPC_XORI: begin cls = C_EXEC; ex_src_b = 3'b011; ex_op = OP_XOR; end
      OPC_LUI:  begin cls = C_EXEC; ex_src_b = 3'b011; ex_op = OP_LUI; end
      OPC_LW:   begin cls = C_EXEC; ex_src_b = 3'b010; is_lw = 1'b1; end
      OPC_SW:   begin cls = C_EXEC; ex_src_b = 3'b010; is_sw = 1'b1; end
      OPC_BEQ:  cls = C_BRANCH;
      OPC_BNE:  begin cls = C_BRANCH; is_bne = 1'b1; end
      OPC_J:    cls = C_JUMP;
      default:  cls = C_ILLEGAL;
    endcase
  end

  // Next state, per-state control outputs and the memory wait counter.
  always_comb begin
    state_d    = state_q;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    reg_we_c   = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 3'b000;
    alu_op     = OP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = 3'b001;
        if (mem_ack) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_b = 3'b100;
        case (cls)
          C_EXEC:   state_d = S_EXEC;
          C_BRANCH: state_d = S_BRANCH;
          C_JUMP:   state_d = S_JUMP;
          default:  state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        alu_src_a = ex_src_a;
        alu_src_b = ex_src_b;
        alu_op    = ex_op;
        state_d   = (is_lw || is_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = is_sw;
        iord      = 1'b1;
        if (mem_ack) begin
          state_d = is_sw ? S_FETCH : S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_we_c   = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_lw;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = OP_SUB;
        pc_we_c   = is_bne ? ~alu_z : alu_z;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_we_c = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // Restart the count on any state change so each access gets a full budget.
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_req_c && !mem_ack) begin
      wait_d = wait_q + 8'd1;
    end
  end

  // State, wait counter and latched opcode/funct registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the small decode registers are reset too, so the decoded class is
    // never X even though it is only consulted after a fetch has loaded it.
    if (!rst_n) begin
      state_q  <= S_FETCH;
      wait_q   <= '0;
      opcode_q <= '0;
      funct_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      wait_q  <= wait_d;
      if (ir_we_c) begin
        opcode_q <= instr[31:26];
        funct_q  <= instr[5:0];
      end
    end
  end

  // Strobes are gated by rst_n so they drop the instant reset asserts, even
  // though the reset state FETCH would otherwise request memory.
  assign ir_we   = rst_n & ir_we_c;
  assign pc_we   = rst_n & pc_we_c;
  assign mem_req = rst_n & mem_req_c;
  assign mem_we  = rst_n & mem_we_c;
  assign reg_we  = rst_n & reg_we_c;

  assign state = state_q;
  assign trap  = (state_q == S_TRAP);

endmodule

// File: doc/ldw_ctrl.md
LDW_CTRL -- requirements
Module: ldw_ctrl

Interface
REQ-001 Parameters SHALL be exactly as follows, one per line:
- ACK_TIMEOUT, 255, maximum cycles to wait for mem_ack before trapping (range 1..255).
REQ-002 Ports SHALL be exactly as follows, one per line:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr  input  32  instruction word from memory, valid with mem_ack in FETCH.
- mem_ack  input  1  memory done, single-cycle pulse.
- alu_z  input  1  ALU zero flag.
- ir_we  output  1  load instruction register.
- pc_we  output  1  load PC from ALU result.
- mem_req  output  1  memory request.
- mem_we  output  1  memory write (with mem_req).
- iord  output  1  address source: 0 = PC, 1 = ALU result register.
- reg_we  output  1  register-file write.
- reg_dst  output  1  destination: 0 = rt, 1 = rd.
- mem_to_reg  output  1  write-back source: 0 = ALU, 1 = memory data.
- alu_src_a  output  2  00 PC, 01 rs, 10 zero-extended shamt.
- alu_src_b  output  3  000 rt, 001 const 4, 010 sext imm, 011 zext imm, 100 sext imm<<2.
- alu_op  output  4  ALU operation code.
- state  output  3  current FSM state, for debug.
- trap  output  1  sticky fault flag.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.

Function
REQ-004 alu_op SHALL use this encoding: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111.
REQ-005 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, JUMP=6, TRAP=7.
REQ-006 FETCH SHALL drive mem_req=1, mem_we=0, iord=0, src_a=00, src_b=001, alu_op=ADD.
- On mem_ack it SHALL pulse ir_we=1 and pc_we=1 (PC+4), then go to DECODE.
REQ-007 DECODE SHALL last one cycle with no writes and src_a=00, src_b=100, alu_op=ADD (branch target).
- It SHALL then go to EXEC for R-type, addi/andi/ori/xori/lui/lw/sw; BRANCH for beq/bne; JUMP for j; TRAP otherwise.
REQ-008 Supported opcodes/functs:
- R-type (opcode 0x00): add 0x20, sub 0x22, and 0x24, or 0x25, xor 0x26, sll 0x00, srl 0x02, sra 0x03.
- I-type: addi 0x08, andi 0x0C, ori 0x0D, xori 0x0E, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
- Jump: j 0x02.
- Any other opcode, or unlisted funct under opcode 0, SHALL be illegal.
REQ-009 EXEC operand selection:
- R-type arithmetic/logic: src_a=01, src_b=000.
- Shifts: src_a=10, src_b=000.
- addi/lw/sw: src_a=01, src_b=010, ADD.
- andi/ori/xori: src_b=011.
- lui: src_b=011, LUI.
REQ-010 EXEC SHALL go to MEM for lw/sw and to WB otherwise.
REQ-011 MEM SHALL drive mem_req=1, iord=1, mem_we=1 for sw only, holding until mem_ack.
- On ack: sw returns to FETCH; lw goes to WB.
REQ-012 WB SHALL pulse reg_we=1 for one cycle, then return to FETCH.
- reg_dst=1 for R-type, 0 otherwise; mem_to_reg=1 for lw only.
REQ-013 BRANCH SHALL drive src_a=01, src_b=000, alu_op=SUB.
- pc_we = alu_z for beq, ~alu_z for bne; then return to FETCH.
REQ-014 JUMP SHALL pulse pc_we=1 (external datapath selects the jump target), then return to FETCH.
REQ-015 Cycle counts with zero-wait ack: R/I-type 4, lw 5, sw 4, branch 3, jump 3.
REQ-016 An 8-bit wait counter SHALL clear on entering FETCH/MEM and increment each cycle mem_req=1 without mem_ack.
- Reaching ACK_TIMEOUT SHALL enter TRAP.
- mem_ack on the same cycle as the limit SHALL win (no trap).
REQ-017 TRAP SHALL set trap=1, deassert every write/request output, and hold until reset.
REQ-018 ir_we, pc_we, reg_we and mem_we SHALL never assert outside the states listed above; mem_ack outside FETCH/MEM SHALL be ignored.

Reset
REQ-019 Asserting rst_n=0 SHALL immediately (asynchronously) force state=FETCH, trap=0, counter=0, and all write/request outputs to 0, including mid-access; outputs stay 0 while rst_n=0.
REQ-020 On the first rising edge after release, FETCH SHALL assert mem_req=1.

Verification
REQ-021 add r3,r1,r2 (0x00221820), ack in FETCH cycle -> states 0,1,2,4; alu_op=0000 in EXEC; reg_we=1, reg_dst=1 in WB.
REQ-022 lw 0x8C220004, MEM ack delayed 3 cycles -> mem_req held with iord=1; reg_we=1, mem_to_reg=1 one cycle after ack.
REQ-023 beq with alu_z=1 then alu_z=0 -> pc_we=1 in BRANCH for the first instance only; bne gives the inverse.
REQ-024 sra (funct 0x03) -> alu_op=1111, src_a=10 in EXEC; opcode 0x3F -> TRAP, trap=1, no further mem_req.
REQ-025 With ACK_TIMEOUT=4 and no ack -> TRAP after 4 request cycles; ack on cycle 4 -> normal DECODE.
REQ-026 rst_n low during MEM of sw -> mem_req and mem_we drop to 0 without a clock edge; FETCH resumes after release.
